register_fd: RTL
================

// Module: register_FD
// PURPOSE
//  IF/ID pipeline register: sits between fetch and decode; its outputs feed decode,
//  which in turn drives the D/EX register. Holds on hazard stalls, injects NOP bubbles
//  on flush/imem stall, and runs a halt FSM that stops fetch once HALT is in flight.
//  Reset loads NOP, not zero, because 16'h0000 decodes as HALT.
// PARAMETERS
//  DATA_W     16        width of instr/PC paths
//  NOP_INSTR  16'h0800  bubble encoding (opcode 00001)
//  HALT_OPC   5'b00000  HALT opcode, compared against instr[15:11]
//  CNT_W      16        width of stall performance counter
// PORTS
//  clk         in   1       clock; all state updates on posedge
//  rst         in   1       synchronous, active-high reset
//  instr       in   DATA_W  fetched instruction
//  pc          in   DATA_W  PC of fetched instruction
//  PC_2        in   DATA_W  pc + 2 from fetch adder
//  imem_stall  in   1       instruction memory not ready this cycle
//  stall_D     in   1       decode hazard stall: hold register contents
//  flush       in   1       branch/jump resolved taken: squash IF/ID
//  halt_retire in   1       HALT reached writeback
//  instr_q     out  DATA_W  instruction to decode
//  pc_q        out  DATA_W  PC to decode
//  PC_2_q      out  DATA_W  PC+2 to decode
//  valid_q     out  1       instr_q is a real instruction (0 = bubble)
//  fetch_hold  out  1       freeze PC register
//  halted      out  1       processor fully halted
//  stall_cnt   out  CNT_W   cycles with stall_D or imem_stall asserted
// BEHAVIOUR
//  Reset: instr_q=NOP_INSTR, pc_q=0, PC_2_q=0, valid_q=0, state=RUN, stall_cnt=0,
//   halted=0. Reset mid-operation (any state) returns to these values next edge.
//  Latency: 1 cycle instr->instr_q when loading.
//  Update priority each edge: rst > flush > stall_D > (imem_stall | state!=RUN) > load.
//   flush: instr_q=NOP_INSTR, valid_q=0; pc_q/PC_2_q don't-care (hold).
//   stall_D (no flush): all outputs hold, including valid_q.
//   imem_stall or HALTING/HALTED: bubble (instr_q=NOP_INSTR, valid_q=0).
//   load: instr_q/pc_q/PC_2_q <= inputs, valid_q=1.
//  flush and stall_D together: flush wins (stall belongs to squashed instr).
//  fetch_hold = stall_D | imem_stall | (state!=RUN) | is_halt_in; combinational,
//   where is_halt_in = instr[15:11]==HALT_OPC & !imem_stall & !flush.
//  FSM:
//   RUN: load of is_halt_in instruction (not stalled, not flushed) -> HALTING.
//   HALTING: flush -> RUN (HALT was wrong-path; next edge loads normally);
//            halt_retire -> HALTED; else stay. flush+halt_retire same cycle -> HALTED.
//   HALTED: absorbing until rst; halted=1; registers hold bubble.
//  stall_cnt: +1 on each edge with (stall_D|imem_stall) & state!=HALTED;
//   saturates at all-ones, no wrap.
// TESTING
//  T1 rst 1 cycle -> instr_q=16'h0800, valid_q=0, pc_q=0, halted=0, stall_cnt=0.
//  T2 load instr=16'hC123 pc=16'h0010 PC_2=16'h0012 -> next edge instr_q=16'hC123,
//     pc_q=16'h0010, PC_2_q=16'h0012, valid_q=1; then stall_D=1 with instr=16'h4444
//     for 3 cycles -> outputs unchanged, stall_cnt=3.
//  T3 stall_D=1 and flush=1 same cycle -> instr_q=16'h0800, valid_q=0;
//     imem_stall=1 alone -> bubble, fetch_hold=1.
//  T4 instr=16'h0000 loaded -> valid_q=1, state HALTING, fetch_hold=1, next cycles
//     instr_q=16'h0800; halt_retire=1 -> halted=1, stays through 10 cycles until rst.
//  T5 HALT loaded then flush=1 next cycle -> back to RUN, instr=16'h9000 loads next edge.
//  T6 force stall_cnt near 16'hFFFF (CNT_W=4 build: 20 stall cycles) -> holds at 4'hF.

Source files
------------

// File: rtl/register_fd.sv
// IF/ID pipeline register with stall hold, bubble injection, a halt FSM that freezes
// fetch once HALT is in flight, and a saturating stall performance counter.
module register_fd #(
    parameter int unsigned       DATA_W    = 16,
    parameter logic [DATA_W-1:0] NOP_INSTR = 16'h0800,
    parameter logic [4:0]        HALT_OPC  = 5'b00000,
    parameter int unsigned       CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] instr,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] PC_2,
    input  logic              imem_stall,
    input  logic              stall_D,
    input  logic              flush,
    input  logic              halt_retire,
    output logic [DATA_W-1:0] instr_q,
    output logic [DATA_W-1:0] pc_q,
    output logic [DATA_W-1:0] PC_2_q,
    output logic              valid_q,
    output logic              fetch_hold,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StHalting = 2'd1,
        StHalted  = 2'd2
    } state_e;

    state_e state, state_next;

    logic is_halt_in;
    logic do_load;
    logic do_bubble;
    logic cnt_en;

    // A fetched HALT only counts when it is real this cycle (memory ready, not squashed).
    assign is_halt_in = (instr[DATA_W-1 -: 5] == HALT_OPC) && !imem_stall && !flush;

    assign do_bubble = !flush && !stall_D && (imem_stall || (state != StRun));
    assign do_load   = !flush && !stall_D && !imem_stall && (state == StRun);

    assign fetch_hold = stall_D || imem_stall || (state != StRun) || is_halt_in;
    assign halted     = (state == StHalted);
    assign cnt_en     = (stall_D || imem_stall) && (state != StHalted);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= StRun;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            StRun: begin
                if (do_load && is_halt_in) begin
                    state_next = StHalting;
                end
            end
            StHalting: begin
                // Retirement proves the HALT was on the correct path, so it beats flush.
                if (halt_retire) begin
                    state_next = StHalted;
                end else if (flush) begin
                    state_next = StRun;
                end
            end
            StHalted: state_next = StHalted;
            default:  state_next = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
            PC_2_q  <= '0;
            valid_q <= 1'b0;
        end else if (flush || do_bubble) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (do_load) begin
            instr_q <= instr;
            pc_q    <= pc;
            PC_2_q  <= PC_2;
            valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (cnt_en && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
